// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side hazard control bundle between the integer core front end and pipe_hazard_ctrl.
// master = core/front end driving decode fields, slave = the hazard control unit.
interface pipe_hazard_ctrl_if #(
    parameter int DEPTH   = 3,
    parameter int RADDR_W = 5,
    parameter int SEL_W   = 2
);
    logic               id_valid;
    logic [RADDR_W-1:0] id_rs1;
    logic [RADDR_W-1:0] id_rs2;
    logic               id_use_rs1;
    logic               id_use_rs2;
    logic [RADDR_W-1:0] id_rd;
    logic               id_regwrite;
    logic               id_is_load;
    logic               ex_branch_taken;
    logic               ext_stall;

    logic               hold_pc;
    logic               id_kill;
    logic [SEL_W-1:0]   fwd_sel1;
    logic [SEL_W-1:0]   fwd_sel2;
    logic [DEPTH-1:0]   stage_valid;
    logic               wb_en;
    logic [RADDR_W-1:0] wb_rd;
    logic [31:0]        perf_stall_cnt;
    logic [31:0]        perf_flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_regwrite, id_is_load, ex_branch_taken, ext_stall,
        input  hold_pc, id_kill, fwd_sel1, fwd_sel2, stage_valid, wb_en, wb_rd,
               perf_stall_cnt, perf_flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_regwrite, id_is_load, ex_branch_taken, ext_stall,
        output hold_pc, id_kill, fwd_sel1, fwd_sel2, stage_valid, wb_en, wb_rd,
               perf_stall_cnt, perf_flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: DEPTH-stage scoreboard, operand forwarding selects, load-use stall,
// taken-branch shadow squash and external freeze. Define PERF_CNT_EN to build stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int DEPTH         = 3,
    parameter int RADDR_W       = 5,
    parameter int LOAD_READY    = 2,
    parameter int BRANCH_SHADOW = 2,
    parameter int SEL_W         = 2
) (
    input logic                clk,
    input logic                rst_n,
    pipe_hazard_ctrl_if.slave  bus
);
    localparam int KW = (BRANCH_SHADOW > 1) ? $clog2(BRANCH_SHADOW) : 1;
    localparam logic [KW-1:0] KILL_LOAD = KW'((BRANCH_SHADOW > 0) ? BRANCH_SHADOW - 1 : 0);

    logic [DEPTH-1:0]              vld_q, vld_d;
    logic [DEPTH-1:0]              wr_q,  wr_d;
    logic [DEPTH-1:0]              ld_q,  ld_d;
    logic [DEPTH-1:0][RADDR_W-1:0] rd_q,  rd_d;
    logic [KW-1:0]                 kill_cnt_q, kill_cnt_d;

    logic             branch_s;
    logic             kill_s;
    logic             live_s;
    logic             lu1_s;
    logic             lu2_s;
    logic             lu_stall_s;
    logic             hold_s;
    logic [SEL_W-1:0] sel1_s;
    logic [SEL_W-1:0] sel2_s;

    function automatic logic src_hit(
        input logic               ent_vld,
        input logic               ent_wr,
        input logic [RADDR_W-1:0] ent_rd,
        input logic [RADDR_W-1:0] rs,
        input logic               use_rs
    );
        return ent_vld & ent_wr & (ent_rd == rs) & (rs != '0) & use_rs;
    endfunction

    // Forwarding select and load-readiness per source; scanning oldest first lets stage 1 win.
    always_comb begin
        sel1_s = '0;
        sel2_s = '0;
        lu1_s  = 1'b0;
        lu2_s  = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (src_hit(vld_q[k-1], wr_q[k-1], rd_q[k-1], bus.id_rs1, bus.id_use_rs1)) begin
                sel1_s = SEL_W'(k);
                lu1_s  = ld_q[k-1] & (k < LOAD_READY);
            end else begin
                sel1_s = sel1_s;
            end
            if (src_hit(vld_q[k-1], wr_q[k-1], rd_q[k-1], bus.id_rs2, bus.id_use_rs2)) begin
                sel2_s = SEL_W'(k);
                lu2_s  = ld_q[k-1] & (k < LOAD_READY);
            end else begin
                sel2_s = sel2_s;
            end
        end
    end

    assign branch_s   = bus.ex_branch_taken & vld_q[0];
    assign kill_s     = (kill_cnt_q != '0) | branch_s;
    assign live_s     = bus.id_valid & ~kill_s;
    assign lu_stall_s = live_s & (lu1_s | lu2_s);
    // Gated by rst_n so hold_pc reads 0 during reset even if the freeze input is high.
    assign hold_s     = rst_n & (bus.ext_stall | lu_stall_s);

    // Scoreboard shift and branch-shadow counter; a freeze holds everything.
    always_comb begin
        vld_d      = vld_q;
        wr_d       = wr_q;
        ld_d       = ld_q;
        rd_d       = rd_q;
        kill_cnt_d = kill_cnt_q;
        if (!bus.ext_stall) begin
            for (int k = 1; k < DEPTH; k++) begin
                vld_d[k] = vld_q[k-1];
                wr_d[k]  = wr_q[k-1];
                ld_d[k]  = ld_q[k-1];
                rd_d[k]  = rd_q[k-1];
            end
            vld_d[0] = live_s & ~lu_stall_s;
            wr_d[0]  = bus.id_regwrite;
            ld_d[0]  = bus.id_is_load;
            rd_d[0]  = bus.id_rd;
            if (branch_s) begin
                kill_cnt_d = KILL_LOAD;
            end else if (bus.id_valid && (kill_cnt_q != '0)) begin
                kill_cnt_d = kill_cnt_q - KW'(1);
            end else begin
                kill_cnt_d = kill_cnt_q;
            end
        end else begin
            kill_cnt_d = kill_cnt_q;
        end
    end

    // Scoreboard and shadow counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q      <= '0;
            wr_q       <= '0;
            ld_q       <= '0;
            rd_q       <= '0;
            kill_cnt_q <= '0;
        end else begin
            vld_q      <= vld_d;
            wr_q       <= wr_d;
            ld_q       <= ld_d;
            rd_q       <= rd_d;
            kill_cnt_q <= kill_cnt_d;
        end
    end

    assign bus.hold_pc     = hold_s;
    assign bus.id_kill     = kill_s;
    assign bus.fwd_sel1    = sel1_s;
    assign bus.fwd_sel2    = sel2_s;
    assign bus.stage_valid = vld_q;
    assign bus.wb_en       = vld_q[DEPTH-1] & wr_q[DEPTH-1] & (rd_q[DEPTH-1] != '0);
    assign bus.wb_rd       = rd_q[DEPTH-1];

`ifdef PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Counters wrap naturally at 2^32.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hold_s) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (branch_s && !bus.ext_stall) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.perf_stall_cnt = stall_cnt_q;
    assign bus.perf_flush_cnt = flush_cnt_q;
`else
    assign bus.perf_stall_cnt = 32'd0;
    assign bus.perf_flush_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, async reset sequence,
// and randomized traffic against a queue-based reference model of the hazard rules.
module tb_pipe_hazard_ctrl;
    localparam int DEPTH         = 3;
    localparam int RADDR_W       = 5;
    localparam int LOAD_READY    = 2;
    localparam int BRANCH_SHADOW = 2;
    localparam int SEL_W         = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.DEPTH(DEPTH), .RADDR_W(RADDR_W), .SEL_W(SEL_W)) bus ();

    pipe_hazard_ctrl #(
        .DEPTH(DEPTH), .RADDR_W(RADDR_W), .LOAD_READY(LOAD_READY),
        .BRANCH_SHADOW(BRANCH_SHADOW), .SEL_W(SEL_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
        logic       br;
        logic       st;
        logic       hold;
        logic       kill;
        logic [1:0] s1;
        logic [1:0] s2;
        logic [2:0] sv;
        logic       wben;
        logic [4:0] wbrd;
    } vec_t;

    typedef struct {
        logic       v;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
    } ent_t;

    vec_t tbl[$];
    ent_t pipe_m[$];
    int   shadow_m;
    int   stall_m;
    int   flush_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic rw, input logic ld, input logic br, input logic st,
                                input logic hold, input logic kill, input logic [1:0] s1,
                                input logic [1:0] s2, input logic [2:0] sv, input logic wben,
                                input logic [4:0] wbrd);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2; t.rd = rd;
        t.rw = rw; t.ld = ld; t.br = br; t.st = st; t.hold = hold; t.kill = kill;
        t.s1 = s1; t.s2 = s2; t.sv = sv; t.wben = wben; t.wbrd = wbrd;
        return t;
    endfunction

    function automatic vec_t idl(input logic [2:0] sv, input logic wben, input logic [4:0] wbrd);
        return mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b0, 2'd0, 2'd0, sv, wben, wbrd);
    endfunction

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic ld, input logic br, input logic st);
        bus.id_valid = v; bus.id_rs1 = rs1; bus.id_rs2 = rs2;
        bus.id_use_rs1 = u1; bus.id_use_rs2 = u2; bus.id_rd = rd;
        bus.id_regwrite = rw; bus.id_is_load = ld;
        bus.ex_branch_taken = br; bus.ext_stall = st;
    endtask

    // Youngest in-flight producer of rs, as a 1-based stage number (0 = register file).
    function automatic int producer(input logic [4:0] rs, input logic use_rs);
        if (!use_rs || rs == 5'd0) return 0;
        for (int k = 0; k < DEPTH; k++)
            if (pipe_m[k].v && pipe_m[k].rw && pipe_m[k].rd == rs) return k + 1;
        return 0;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, " hold"}, 32'(bus.hold_pc), 32'd0);
        chk({tag, " kill"}, 32'(bus.id_kill), 32'd0);
        chk({tag, " sel1"}, 32'(bus.fwd_sel1), 32'd0);
        chk({tag, " sel2"}, 32'(bus.fwd_sel2), 32'd0);
        chk({tag, " sv"}, 32'(bus.stage_valid), 32'd0);
        chk({tag, " wb_en"}, 32'(bus.wb_en), 32'd0);
        chk({tag, " wb_rd"}, 32'(bus.wb_rd), 32'd0);
        chk({tag, " perf_stall"}, bus.perf_stall_cnt, 32'd0);
        chk({tag, " perf_flush"}, bus.perf_flush_cnt, 32'd0);
    endtask

    initial begin
        // Forwarding chain, load-use, branch shadow, freeze (plain and during shadow), x0.
        tbl.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0,  0, 0, 0, 0, 3'b000, 0, 0));
        tbl.push_back(mk(1, 5, 0, 1, 1, 6, 1, 0, 0, 0,  0, 0, 1, 0, 3'b001, 0, 0));
        tbl.push_back(mk(1, 5, 6, 1, 1, 8, 1, 0, 0, 0,  0, 0, 2, 1, 3'b011, 0, 0));
        tbl.push_back(idl(3'b111, 1, 5));
        tbl.push_back(idl(3'b110, 1, 6));
        tbl.push_back(idl(3'b100, 1, 8));
        tbl.push_back(mk(1, 1, 0, 1, 0, 7, 1, 1, 0, 0,  0, 0, 0, 0, 3'b000, 0, 0));
        tbl.push_back(mk(1, 7, 0, 1, 0, 9, 1, 0, 0, 0,  1, 0, 1, 0, 3'b001, 0, 0));
        tbl.push_back(mk(1, 7, 0, 1, 0, 9, 1, 0, 0, 0,  0, 0, 2, 0, 3'b010, 0, 0));
        tbl.push_back(idl(3'b101, 1, 7));
        tbl.push_back(idl(3'b010, 0, 0));
        tbl.push_back(idl(3'b100, 1, 9));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3'b000, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 10, 1, 0, 1, 0, 0, 1, 0, 0, 3'b001, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 11, 1, 0, 0, 0, 0, 1, 0, 0, 3'b010, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0, 0, 0, 0, 3'b100, 0, 0));
        tbl.push_back(idl(3'b001, 0, 0));
        tbl.push_back(idl(3'b010, 0, 0));
        tbl.push_back(idl(3'b100, 1, 12));
        tbl.push_back(mk(1, 0, 0, 0, 0, 13, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0));
        tbl.push_back(mk(1, 13, 0, 1, 0, 14, 1, 0, 0, 0, 0, 0, 1, 0, 3'b001, 0, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 13, 14, 1, 1, 15, 1, 0, 0, 1, 1, 0, 2, 1, 3'b011, 0, 0));
        tbl.push_back(mk(1, 13, 14, 1, 1, 15, 1, 0, 0, 0, 0, 0, 2, 1, 3'b011, 0, 0));
        tbl.push_back(idl(3'b111, 1, 13));
        tbl.push_back(idl(3'b110, 1, 14));
        tbl.push_back(idl(3'b100, 1, 15));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3'b000, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 20, 1, 0, 1, 0, 0, 1, 0, 0, 3'b001, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 21, 1, 0, 0, 1, 1, 1, 0, 0, 3'b010, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 21, 1, 0, 0, 1, 1, 1, 0, 0, 3'b010, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 21, 1, 0, 0, 0, 0, 1, 0, 0, 3'b010, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 16, 1, 0, 0, 0, 0, 0, 0, 0, 3'b100, 0, 0));
        tbl.push_back(idl(3'b001, 0, 0));
        tbl.push_back(idl(3'b010, 0, 0));
        tbl.push_back(idl(3'b100, 1, 16));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 3'b000, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 1, 1, 0, 0, 0,  0, 0, 0, 0, 3'b001, 0, 0));
        tbl.push_back(idl(3'b011, 0, 0));
        tbl.push_back(idl(3'b110, 0, 0));
        tbl.push_back(idl(3'b100, 1, 1));

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rd,
                  tbl[i].rw, tbl[i].ld, tbl[i].br, tbl[i].st);
            #1;
            chk($sformatf("row%0d hold", i), 32'(bus.hold_pc), 32'(tbl[i].hold));
            chk($sformatf("row%0d kill", i), 32'(bus.id_kill), 32'(tbl[i].kill));
            chk($sformatf("row%0d sel1", i), 32'(bus.fwd_sel1), 32'(tbl[i].s1));
            chk($sformatf("row%0d sel2", i), 32'(bus.fwd_sel2), 32'(tbl[i].s2));
            chk($sformatf("row%0d sv", i), 32'(bus.stage_valid), 32'(tbl[i].sv));
            chk($sformatf("row%0d wb_en", i), 32'(bus.wb_en), 32'(tbl[i].wben));
            if (tbl[i].wben) chk($sformatf("row%0d wb_rd", i), 32'(bus.wb_rd), 32'(tbl[i].wbrd));
        end

        // Three writers in flight, a reader in decode, then an asynchronous reset mid-cycle.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1, 0, 0, 0, 0, 5'(3 + i), 1, 0, 0, 0);
        end
        @(negedge clk);
        drive(1, 5, 4, 1, 1, 9, 1, 0, 0, 0);
        #1;
        chk("pre_rst sv", 32'(bus.stage_valid), 32'd7);
        chk("pre_rst sel1", 32'(bus.fwd_sel1), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("post_rst%0d wb_en", i), 32'(bus.wb_en), 32'd0);
            chk($sformatf("post_rst%0d sv", i), 32'(bus.stage_valid), 32'd0);
            chk($sformatf("post_rst%0d perf_stall", i), bus.perf_stall_cnt, 32'd0);
        end

        // Randomized traffic against the reference model; pipe is empty here.
        for (int k = 0; k < DEPTH; k++) pipe_m.push_back('{v: 1'b0, rd: 5'd0, rw: 1'b0, ld: 1'b0});
        shadow_m = 0;
        stall_m  = 0;
        flush_m  = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic       v, u1, u2, rw, ld, br, st;
            logic [4:0] rs1, rs2, rd;
            int         e_s1, e_s2;
            logic       e_taken, e_kill, e_live, e_lu, e_hold, e_wben;
            logic [2:0] e_sv;
            ent_t       ne;
            @(negedge clk);
            v   = ($urandom_range(0, 9) < 8);
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            u1  = ($urandom_range(0, 9) < 8);
            u2  = ($urandom_range(0, 9) < 6);
            rd  = 5'($urandom_range(0, 7));
            rw  = ($urandom_range(0, 9) < 7);
            ld  = ($urandom_range(0, 9) < 3);
            br  = ($urandom_range(0, 99) < 15);
            st  = ($urandom_range(0, 99) < 10);
            drive(v, rs1, rs2, u1, u2, rd, rw, ld, br, st);
            e_taken = br && pipe_m[0].v;
            e_kill  = (shadow_m > 0) || e_taken;
            e_live  = v && !e_kill;
            e_s1    = producer(rs1, u1);
            e_s2    = producer(rs2, u2);
            e_lu    = e_live && ((e_s1 != 0 && e_s1 < LOAD_READY && pipe_m[e_s1-1].ld) ||
                                 (e_s2 != 0 && e_s2 < LOAD_READY && pipe_m[e_s2-1].ld));
            e_hold  = st || e_lu;
            for (int k = 0; k < DEPTH; k++) e_sv[k] = pipe_m[k].v;
            e_wben  = pipe_m[DEPTH-1].v && pipe_m[DEPTH-1].rw && pipe_m[DEPTH-1].rd != 5'd0;
            #1;
            chk($sformatf("rnd%0d hold", cyc), 32'(bus.hold_pc), 32'(e_hold));
            chk($sformatf("rnd%0d kill", cyc), 32'(bus.id_kill), 32'(e_kill));
            chk($sformatf("rnd%0d sel1", cyc), 32'(bus.fwd_sel1), 32'(e_s1));
            chk($sformatf("rnd%0d sel2", cyc), 32'(bus.fwd_sel2), 32'(e_s2));
            chk($sformatf("rnd%0d sv", cyc), 32'(bus.stage_valid), 32'(e_sv));
            chk($sformatf("rnd%0d wb_en", cyc), 32'(bus.wb_en), 32'(e_wben));
            if (e_wben) chk($sformatf("rnd%0d wb_rd", cyc), 32'(bus.wb_rd), 32'(pipe_m[DEPTH-1].rd));
`ifdef PERF_CNT_EN
            chk($sformatf("rnd%0d perf_stall", cyc), bus.perf_stall_cnt, 32'(stall_m));
            chk($sformatf("rnd%0d perf_flush", cyc), bus.perf_flush_cnt, 32'(flush_m));
`else
            chk($sformatf("rnd%0d perf_stall", cyc), bus.perf_stall_cnt, 32'd0);
            chk($sformatf("rnd%0d perf_flush", cyc), bus.perf_flush_cnt, 32'd0);
`endif
            @(posedge clk);
            stall_m += int'(e_hold);
            if (!st) begin
                flush_m += int'(e_taken);
                ne.v  = e_live && !e_lu;
                ne.rd = rd;
                ne.rw = rw;
                ne.ld = ld;
                pipe_m.push_front(ne);
                void'(pipe_m.pop_back());
                if (e_taken) shadow_m = BRANCH_SHADOW - 1;
                else if (v && shadow_m > 0) shadow_m--;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
